// File: rtl/busy_bit_table_if.sv
// Rename/writeback/recall bundle feeding the busy bit table; bbt returns to the issue queues.
interface busy_bit_table_if #(
    parameter int NUM_PREG = 64,
    parameter int AL_DEPTH = 32,
    parameter int NUM_WB   = 2
);
    localparam int PW = $clog2(NUM_PREG);
    localparam int AW = $clog2(AL_DEPTH);

    logic                        ext_stall;
    logic [1:0]                  alloc_valid;
    logic [1:0][PW-1:0]          alloc_preg;
    logic [1:0][AW-1:0]          alloc_al_addr;
    logic [NUM_WB-1:0]           wb_valid;
    logic [NUM_WB-1:0][PW-1:0]   wb_preg;
    logic                        if_recall;
    logic [AW-1:0]               new_front;
    logic [AW-1:0]               old_front;
    logic [NUM_PREG-1:0]         bbt;

    modport master (
        output ext_stall, alloc_valid, alloc_preg, alloc_al_addr,
        output wb_valid, wb_preg, if_recall, new_front, old_front,
        input  bbt
    );

    modport slave (
        input  ext_stall, alloc_valid, alloc_preg, alloc_al_addr,
        input  wb_valid, wb_preg, if_recall, new_front, old_front,
        output bbt
    );
endinterface

// File: rtl/busy_bit_table.sv
// Physical-register busy vector: set on rename, cleared on writeback or recall; bbt registered (1 cycle).
// Optional BBT_WB_BYPASS_EN masks same-cycle writebacks straight into bbt; no backpressure, always accepts.
module busy_bit_table #(
    parameter int NUM_PREG = 64,
    parameter int AL_DEPTH = 32,
    parameter int NUM_WB   = 2
) (
    input  logic              clk,
    input  logic              reset,
    busy_bit_table_if.slave   bus
);
    localparam int PW = $clog2(NUM_PREG);
    localparam int AW = $clog2(AL_DEPTH);

    logic [NUM_PREG-1:0] r_busy;
    logic [PW-1:0]       r_al_preg [AL_DEPTH];
    logic [AL_DEPTH-1:0] r_al_has_rd;

    logic                w_alloc_en;
    logic [AW-1:0]       w_span;
    logic [AL_DEPTH-1:0] w_flush;
    logic [NUM_PREG-1:0] w_set_mask;
    logic [NUM_PREG-1:0] w_wb_mask;
    logic [NUM_PREG-1:0] w_rcl_mask;
    logic [NUM_PREG-1:0] w_busy_nxt;

    assign w_alloc_en = ~bus.if_recall & ~bus.ext_stall;
    assign w_span     = bus.old_front - bus.new_front;

    always_comb begin
        w_set_mask = '0;
        w_wb_mask  = '0;
        for (int k = 0; k < 2; k++) begin
            if (w_alloc_en && bus.alloc_valid[k]) begin
                w_set_mask[bus.alloc_preg[k]] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_WB; j++) begin
            if (bus.wb_valid[j]) begin
                w_wb_mask[bus.wb_preg[j]] = 1'b1;
            end
        end
        // preg 0 backs x0 and can never be waited on
        w_set_mask[0] = 1'b0;
    end

    // Ring-distance test: the AW-bit subtraction wraps through slot 0 on its own
    always_comb begin
        w_flush    = '0;
        w_rcl_mask = '0;
        for (int a = 0; a < AL_DEPTH; a++) begin
            w_flush[a] = bus.if_recall && ((AW'(a) - bus.new_front) < w_span);
            if (w_flush[a] && r_al_has_rd[a]) begin
                w_rcl_mask[r_al_preg[a]] = 1'b1;
            end
        end
    end

    // Sets are OR'd last so a re-allocated preg outranks a stale clear
    assign w_busy_nxt = ((r_busy & ~w_wb_mask & ~w_rcl_mask) | w_set_mask)
                        & ~NUM_PREG'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= '0;
            r_al_has_rd <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            for (int a = 0; a < AL_DEPTH; a++) begin
                if (w_flush[a]) begin
                    r_al_has_rd[a] <= 1'b0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (w_alloc_en && bus.alloc_valid[k]) begin
                    r_al_has_rd[bus.alloc_al_addr[k]] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (w_alloc_en && bus.alloc_valid[k]) begin
                r_al_preg[bus.alloc_al_addr[k]] <= bus.alloc_preg[k];
            end
        end
    end

`ifdef BBT_WB_BYPASS_EN
    assign bus.bbt = r_busy & ~(w_wb_mask & ~w_set_mask);
`else
    assign bus.bbt = r_busy;
`endif

endmodule
